sd_block_sequencer: RTL and testbench

- Memory-mapped controller that sequences multi-sector reads from the SD card byte-stream controller for the MIPS core.
- The CPU programs a start sector and a block count, then starts the transfer. The block issues one read per sector, packs the 512 returned bytes into a 128x32 buffer, and raises block_ready.
- The CPU reads the buffer through a bus window, then acks to fetch the next sector.
- Sits between the data bus and the SD byte controller, replacing direct CPU polling of single bytes.

---
 rtl/sd_block_sequencer_if.sv | 29 ++
 rtl/sd_block_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_sd_block_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_sequencer_if.sv
// Bus-side and SD-controller-side signals of the SD block sequencer.
// "master" is the environment (CPU bus + SD byte controller); "slave" is the sequencer.
interface sd_block_sequencer_if;
    logic        wReadEnable;
    logic        wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [31:0] wAddress;
    logic [31:0] wWriteData;
    logic [31:0] wReadData;
    logic        sd_rd;
    logic [31:0] sd_address;
    logic [7:0]  sd_dout;
    logic        sd_byte_available;
    logic        sd_ready;

    modport master (
        output wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData,
        input  wReadData,
        input  sd_rd, sd_address,
        output sd_dout, sd_byte_available, sd_ready
    );

    modport slave (
        input  wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData,
        output wReadData,
        output sd_rd, sd_address,
        input  sd_dout, sd_byte_available, sd_ready
    );
endinterface

// File: rtl/sd_block_sequencer.sv
// Memory-mapped multi-sector read sequencer: issues one SD read per sector and
// packs the 512 returned bytes into a 128-word buffer the CPU reads through a window.
module sd_block_sequencer #(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF0300,
    parameter bit          BYTE_ADDR      = 1'b1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic                iCLK,
    input  logic                Reset,
    sd_block_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_RECV  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_r, next_state_s;
    logic [31:0] sector_r, cur_sector_r, sd_address_r;
    logic [15:0] count_r, remaining_r;
    logic        busy_r, block_ready_r, done_r, error_r, sd_rd_r;
    logic [1:0]  byte_cnt_r;
    logic [6:0]  word_cnt_r;
    logic [23:0] tmo_cnt_r;
    logic [31:0] buf_mem [0:127];

    logic [31:0] off_s, rd_data_s;
    logic        rd_hit_s, start_s, ack_s, abort_s, sector_wr_s, count_wr_s;
    logic        strobe_s, last_byte_s, timeout_s;
    logic        launch_s, empty_start_s, rd_set_s, rd_accept_s, quit_s, tmo_run_s;
    logic        count_byte_s, store_byte_s, block_done_s, fail_s, hold_done_s, hold_next_s;
    logic        unused_s;

    function automatic logic [31:0] sector_to_addr(input logic [31:0] sector);
        return BYTE_ADDR ? {sector[22:0], 9'd0} : sector;
    endfunction

    // Offset-based decode: the base is not 1 KiB aligned, so buffer words index from the offset.
    assign off_s       = bus.wAddress - BASE_ADDR;
    assign start_s     = bus.wWriteEnable && (off_s == 32'h0) && bus.wWriteData[0];
    assign ack_s       = bus.wWriteEnable && (off_s == 32'h0) && bus.wWriteData[1];
    assign abort_s     = bus.wWriteEnable && (off_s == 32'h0) && bus.wWriteData[2];
    assign sector_wr_s = bus.wWriteEnable && (off_s == 32'h4) && !busy_r;
    assign count_wr_s  = bus.wWriteEnable && (off_s == 32'h8) && !busy_r;
    assign strobe_s    = bus.sd_byte_available;
    assign last_byte_s = &{word_cnt_r, byte_cnt_r};
    assign timeout_s   = !strobe_s && (tmo_cnt_r == TIMEOUT_CYCLES - 24'd1);
    assign unused_s    = ^bus.wByteEnable;
    assign bus.sd_rd      = sd_rd_r;
    assign bus.sd_address = sd_address_r;

    // State register.
    always_ff @(posedge iCLK) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort outranks ack and start.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && !abort_s && (count_r != 16'd0)) next_state_s = ST_ISSUE;
                else                                           next_state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (sd_rd_r && !bus.sd_ready) next_state_s = abort_s ? ST_DRAIN : ST_RECV;
                else if (abort_s)             next_state_s = ST_IDLE;
                else                          next_state_s = ST_ISSUE;
            end
            ST_RECV: begin
                if (strobe_s && last_byte_s) next_state_s = abort_s ? ST_IDLE : ST_HOLD;
                else if (abort_s)            next_state_s = ST_DRAIN;
                else if (timeout_s)          next_state_s = ST_IDLE;
                else                         next_state_s = ST_RECV;
            end
            ST_HOLD: begin
                if (abort_s)    next_state_s = ST_IDLE;
                else if (ack_s) next_state_s = (remaining_r == 16'd0) ? ST_IDLE : ST_ISSUE;
                else            next_state_s = ST_HOLD;
            end
            ST_DRAIN: begin
                if ((strobe_s && last_byte_s) || timeout_s) next_state_s = ST_IDLE;
                else                                        next_state_s = ST_DRAIN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes consumed by the datapath.
    always_comb begin
        launch_s      = 1'b0;
        empty_start_s = 1'b0;
        rd_set_s      = 1'b0;
        rd_accept_s   = 1'b0;
        quit_s        = 1'b0;
        tmo_run_s     = 1'b0;
        count_byte_s  = 1'b0;
        store_byte_s  = 1'b0;
        block_done_s  = 1'b0;
        fail_s        = 1'b0;
        hold_done_s   = 1'b0;
        hold_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                launch_s      = start_s && !abort_s && (count_r != 16'd0);
                empty_start_s = start_s && !abort_s && (count_r == 16'd0);
            end
            ST_ISSUE: begin
                rd_accept_s = sd_rd_r && !bus.sd_ready;
                rd_set_s    = !abort_s && !sd_rd_r && bus.sd_ready;
                quit_s      = abort_s && !(sd_rd_r && !bus.sd_ready);
            end
            ST_RECV: begin
                tmo_run_s    = 1'b1;
                count_byte_s = strobe_s;
                store_byte_s = strobe_s && !abort_s;
                block_done_s = strobe_s && last_byte_s && !abort_s;
                quit_s       = strobe_s && last_byte_s && abort_s;
                fail_s       = timeout_s && !abort_s;
            end
            ST_HOLD: begin
                quit_s      = abort_s;
                hold_done_s = !abort_s && ack_s && (remaining_r == 16'd0);
                hold_next_s = !abort_s && ack_s && (remaining_r != 16'd0);
            end
            ST_DRAIN: begin
                tmo_run_s    = 1'b1;
                count_byte_s = strobe_s;
                quit_s       = (strobe_s && last_byte_s) || timeout_s;
            end
            default: begin
                quit_s = 1'b0;
            end
        endcase
    end

    // Registers, status flags, SD request and byte/timeout counters.
    always_ff @(posedge iCLK) begin
        if (Reset) begin
            sector_r      <= 32'd0;
            count_r       <= 16'd0;
            cur_sector_r  <= 32'd0;
            remaining_r   <= 16'd0;
            sd_address_r  <= 32'd0;
            sd_rd_r       <= 1'b0;
            busy_r        <= 1'b0;
            block_ready_r <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            byte_cnt_r    <= 2'd0;
            word_cnt_r    <= 7'd0;
            tmo_cnt_r     <= 24'd0;
        end else begin
            if (sector_wr_s) sector_r <= bus.wWriteData;
            if (count_wr_s)  count_r  <= bus.wWriteData[15:0];
            if (launch_s) begin
                cur_sector_r <= sector_r;
                remaining_r  <= count_r;
                busy_r       <= 1'b1;
                done_r       <= 1'b0;
                error_r      <= 1'b0;
            end
            if (empty_start_s) begin
                done_r  <= 1'b1;
                error_r <= 1'b0;
            end
            if (rd_set_s) begin
                sd_rd_r      <= 1'b1;
                sd_address_r <= sector_to_addr(cur_sector_r);
            end
            if (rd_accept_s) begin
                sd_rd_r    <= 1'b0;
                byte_cnt_r <= 2'd0;
                word_cnt_r <= 7'd0;
                tmo_cnt_r  <= 24'd0;
            end
            if (count_byte_s) {word_cnt_r, byte_cnt_r} <= {word_cnt_r, byte_cnt_r} + 9'd1;
            if (tmo_run_s)    tmo_cnt_r <= strobe_s ? 24'd0 : tmo_cnt_r + 24'd1;
            if (block_done_s) begin
                block_ready_r <= 1'b1;
                remaining_r   <= remaining_r - 16'd1;
                cur_sector_r  <= cur_sector_r + 32'd1;
            end
            if (fail_s) begin
                error_r <= 1'b1;
                busy_r  <= 1'b0;
            end
            if (hold_done_s) begin
                block_ready_r <= 1'b0;
                done_r        <= 1'b1;
                busy_r        <= 1'b0;
            end
            if (hold_next_s) block_ready_r <= 1'b0;
            if (quit_s) begin
                sd_rd_r       <= 1'b0;
                busy_r        <= 1'b0;
                done_r        <= 1'b0;
                error_r       <= 1'b0;
                block_ready_r <= 1'b0;
            end
        end
    end

    // Sector buffer; little-endian byte packing, no reset.
    always_ff @(posedge iCLK) begin
        if (store_byte_s) buf_mem[word_cnt_r][{byte_cnt_r, 3'b000} +: 8] <= bus.sd_dout;
    end

    // Combinational read window, high-impedance when not selected.
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_data_s = 32'd0;
        if (bus.wReadEnable) begin
            case (off_s)
                32'h4: begin rd_hit_s = 1'b1; rd_data_s = sector_r; end
                32'h8: begin rd_hit_s = 1'b1; rd_data_s = {16'd0, count_r}; end
                32'hC: begin
                    rd_hit_s  = 1'b1;
                    rd_data_s = {remaining_r, 12'd0, error_r, done_r, block_ready_r, busy_r};
                end
                default: begin
                    rd_hit_s  = (off_s[31:9] == 23'd1);
                    rd_data_s = buf_mem[off_s[8:2]];
                end
            endcase
        end else begin
            rd_hit_s  = 1'b0;
            rd_data_s = 32'd0;
        end
        bus.wReadData = rd_hit_s ? rd_data_s : 32'bz;
    end
endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench: a byte-addressed and a sector-addressed sequencer run in lockstep
// from one bus driver and one SD byte-source model.
`timescale 1ns/1ps
module tb_sd_block_sequencer;
    localparam logic [31:0] BASE     = 32'hFFFF0300;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_SECTOR = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;
    localparam logic [31:0] A_BUF    = BASE + 32'h200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [7:0]  sd_dout = 8'd0;
    logic        sd_bav = 1'b0;
    logic        sd_ready = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sd_block_sequencer_if if_a ();
    sd_block_sequencer_if if_b ();

    assign if_a.wReadEnable = rd_en;    assign if_b.wReadEnable = rd_en;
    assign if_a.wWriteEnable = wr_en;   assign if_b.wWriteEnable = wr_en;
    assign if_a.wByteEnable = 4'hF;     assign if_b.wByteEnable = 4'hF;
    assign if_a.wAddress = addr;        assign if_b.wAddress = addr;
    assign if_a.wWriteData = wdata;     assign if_b.wWriteData = wdata;
    assign if_a.sd_dout = sd_dout;      assign if_b.sd_dout = sd_dout;
    assign if_a.sd_byte_available = sd_bav; assign if_b.sd_byte_available = sd_bav;
    assign if_a.sd_ready = sd_ready;    assign if_b.sd_ready = sd_ready;

    sd_block_sequencer #(.BASE_ADDR(BASE), .BYTE_ADDR(1'b1), .TIMEOUT_CYCLES(24'd1000))
        dut_a (.iCLK(clk), .Reset(rst), .bus(if_a));
    sd_block_sequencer #(.BASE_ADDR(BASE), .BYTE_ADDR(1'b0), .TIMEOUT_CYCLES(24'd1000))
        dut_b (.iCLK(clk), .Reset(rst), .bus(if_b));

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = base + 8'(4*w + j);
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        #1;
        d = if_a.wReadData;
        rd_en = 1'b0;
    endtask

    task automatic wait_rd();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_a.sd_rd === 1'b1) begin ok = 1'b1; break; end
            cycle();
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wait_sd_rd: got sd_rd=%b expected 1 within 20 cycles", if_a.sd_rd); end
    endtask

    // Accept the pending read (drop sd_ready) and step into the byte phase.
    task automatic wait_issue(output logic [31:0] aa, output logic [31:0] ab);
        wait_rd();
        aa = if_a.sd_address;
        ab = if_b.sd_address;
        sd_ready = 1'b0;
        cycle();
    endtask

    task automatic stream(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            sd_dout = base + 8'(i);
            sd_bav = 1'b1;
            cycle();
        end
        sd_bav = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        n_tests++; if (if_a.sd_rd !== 1'b0 || if_b.sd_rd !== 1'b0) begin n_fail++; $display("FAIL reset_sd_rd: got %b/%b expected 0", if_a.sd_rd, if_b.sd_rd); end
        n_tests++; if (if_a.sd_address !== 32'd0) begin n_fail++; $display("FAIL reset_sd_address: got %h expected 0", if_a.sd_address); end
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
        bus_read(A_SECTOR, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_sector: got %h expected 0", d); end
        bus_read(A_COUNT, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", d); end
    endtask

    task automatic test_count_zero();
        logic [31:0] d;
        bit seen_rd;
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL count0_done: got %h expected 00000004", d); end
        seen_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (if_a.sd_rd !== 1'b0) seen_rd = 1'b1;
            cycle();
        end
        n_tests++; if (seen_rd) begin n_fail++; $display("FAIL count0_no_rd: got sd_rd=1 expected 0"); end
    endtask

    task automatic test_single_block();
        logic [31:0] d, aa, ab;
        bus_write(A_SECTOR, 32'd5);
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        wait_issue(aa, ab);
        n_tests++; if (aa !== 32'h0000_0A00) begin n_fail++; $display("FAIL single_addr_byte: got %h expected 00000a00", aa); end
        n_tests++; if (ab !== 32'h0000_0005) begin n_fail++; $display("FAIL single_addr_sector: got %h expected 00000005", ab); end
        stream(511, 8'h00);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL single_before_last: got %h expected 00010001", d); end
        stream(1, 8'hFF);
        sd_ready = 1'b1;
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL single_block_ready: got %h expected 00000003", d); end
        bus_read(A_BUF, d);
        n_tests++; if (d !== 32'h0302_0100) begin n_fail++; $display("FAIL single_buf0: got %h expected 03020100", d); end
        bus_read(A_BUF + 32'd252, d);
        n_tests++; if (d !== 32'hFFFE_FDFC) begin n_fail++; $display("FAIL single_buf63: got %h expected fffefdfc", d); end
        bus_read(A_BUF + 32'd256, d);
        n_tests++; if (d !== 32'h0302_0100) begin n_fail++; $display("FAIL single_buf64: got %h expected 03020100", d); end
        bus_write(A_CTRL, 32'h2);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL single_done: got %h expected 00000004", d); end
    endtask

    task automatic test_multi_block();
        logic [31:0] d, aa, ab;
        bit seen_rd;
        bus_write(A_SECTOR, 32'h10);
        bus_write(A_COUNT, 32'd3);
        bus_write(A_CTRL, 32'h1);
        for (int k = 0; k < 3; k++) begin
            wait_issue(aa, ab);
            n_tests++; if (ab !== 32'h10 + 32'(k)) begin n_fail++; $display("FAIL multi_addr_sector%0d: got %h expected %h", k, ab, 32'h10 + 32'(k)); end
            n_tests++; if (aa !== (32'h10 + 32'(k)) << 9) begin n_fail++; $display("FAIL multi_addr_byte%0d: got %h expected %h", k, aa, (32'h10 + 32'(k)) << 9); end
            stream(512, 8'(7*k));
            sd_ready = 1'b1;
            bus_read(A_STATUS, d);
            n_tests++; if (d !== {16'(2 - k), 16'h0003}) begin n_fail++; $display("FAIL multi_status%0d: got %h expected %h", k, d, {16'(2 - k), 16'h0003}); end
            bus_read(A_BUF + 32'd40, d);
            n_tests++; if (d !== exp_word(8'(7*k), 10)) begin n_fail++; $display("FAIL multi_buf10_%0d: got %h expected %h", k, d, exp_word(8'(7*k), 10)); end
            seen_rd = 1'b0;
            for (int i = 0; i < 5; i++) begin
                cycle();
                if (if_a.sd_rd !== 1'b0 || if_b.sd_rd !== 1'b0) seen_rd = 1'b1;
            end
            n_tests++; if (seen_rd) begin n_fail++; $display("FAIL multi_hold_no_rd%0d: got sd_rd=1 expected 0", k); end
            bus_write(A_CTRL, 32'h2);
        end
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL multi_done: got %h expected 00000004", d); end
    endtask

    task automatic test_timeout();
        logic [31:0] d, aa, ab;
        bus_write(A_SECTOR, 32'd7);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CTRL, 32'h1);
        wait_issue(aa, ab);
        stream(100, 8'h40);
        repeat (999) cycle();
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0002_0001) begin n_fail++; $display("FAIL timeout_999: got %h expected 00020001", d); end
        cycle();
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0002_0008) begin n_fail++; $display("FAIL timeout_1000: got %h expected 00020008", d); end
        sd_ready = 1'b1;
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL timeout_restart: got %h expected 00010001", d); end
        // Abort while the read is still pending: straight back to idle.
        wait_rd();
        bus_write(A_CTRL, 32'h4);
        n_tests++; if (if_a.sd_rd !== 1'b0) begin n_fail++; $display("FAIL issue_abort_rd: got %b expected 0", if_a.sd_rd); end
        bus_read(A_STATUS, d);
        n_tests++; if (d[3:0] !== 4'h0) begin n_fail++; $display("FAIL issue_abort_status: got %h expected 0", d[3:0]); end
    endtask

    task automatic test_abort();
        logic [31:0] d, aa, ab;
        bus_write(A_SECTOR, 32'h20);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CTRL, 32'h1);
        wait_issue(aa, ab);
        stream(200, 8'h80);
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0002_0001) begin n_fail++; $display("FAIL abort_draining: got %h expected 00020001", d); end
        bus_write(A_SECTOR, 32'h99);
        stream(311, 8'hEE);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0002_0001) begin n_fail++; $display("FAIL abort_drain_511: got %h expected 00020001", d); end
        stream(1, 8'h00);
        sd_ready = 1'b1;
        bus_read(A_STATUS, d);
        n_tests++; if (d[3:0] !== 4'h0) begin n_fail++; $display("FAIL abort_idle_status: got %h expected 0", d[3:0]); end
        bus_read(A_SECTOR, d);
        n_tests++; if (d !== 32'h20) begin n_fail++; $display("FAIL abort_sector_kept: got %h expected 00000020", d); end
        bus_read(A_BUF + 32'd196, d);
        n_tests++; if (d !== exp_word(8'h80, 49)) begin n_fail++; $display("FAIL abort_buf49: got %h expected %h", d, exp_word(8'h80, 49)); end
        bus_read(A_BUF + 32'd200, d);
        n_tests++; if (d !== exp_word(8'd14, 50)) begin n_fail++; $display("FAIL abort_buf50: got %h expected %h", d, exp_word(8'd14, 50)); end
        bus_read(A_BUF + 32'd508, d);
        n_tests++; if (d !== exp_word(8'd14, 127)) begin n_fail++; $display("FAIL abort_buf127: got %h expected %h", d, exp_word(8'd14, 127)); end
        cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, aa, ab;
        bus_write(A_SECTOR, 32'd3);
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        wait_issue(aa, ab);
        stream(50, 8'h33);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sd_ready = 1'b1;
        n_tests++; if (if_a.sd_rd !== 1'b0) begin n_fail++; $display("FAIL midreset_sd_rd: got %b expected 0", if_a.sd_rd); end
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_status: got %h expected 0", d); end
        bus_read(A_SECTOR, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_sector: got %h expected 0", d); end
        bus_write(A_SECTOR, 32'd9);
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        wait_issue(aa, ab);
        n_tests++; if (aa !== 32'h0000_1200) begin n_fail++; $display("FAIL midreset_addr: got %h expected 00001200", aa); end
        stream(512, 8'h55);
        sd_ready = 1'b1;
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL midreset_ready: got %h expected 00000003", d); end
        bus_read(A_BUF + 32'd20, d);
        n_tests++; if (d !== exp_word(8'h55, 5)) begin n_fail++; $display("FAIL midreset_buf5: got %h expected %h", d, exp_word(8'h55, 5)); end
        bus_write(A_CTRL, 32'h2);
        bus_read(A_STATUS, d);
        n_tests++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL midreset_done: got %h expected 00000004", d); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_count_zero();
        test_single_block();
        test_multi_block();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
